moore_seq_ctrl: RTL and testbench

- Parametrised Moore step controller.
- A rising edge on the advance input moves a state register one step up or down through NSTATES positions, with direction set by the select input.
- Outputs are decoded only from registered state, in binary or Gray encoding.
- A dwell counter enforces a minimum spacing between accepted steps.
- Wrap-around or saturation at the ends is a parameter choice.

---
 rtl/moore_seq_ctrl.sv | 82 ++++++++
 tb/tb_moore_seq_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/moore_seq_ctrl.sv
// rtl/moore_seq_ctrl.sv - Moore step controller: edge-triggered up/down stepping with dwell spacing.
// Outputs decode only from registered state; ends either wrap or saturate.
module moore_seq_ctrl #(
  parameter int WIDTH   = 2,
  parameter int NSTATES = 4,
  parameter int DWELL   = 3,
  parameter int WRAP    = 1,
  parameter int GRAY    = 0
) (
  input  logic             inputClk,
  input  logic             inputReset,
  input  logic             inputI,
  input  logic             inputS,
  output logic [WIDTH-1:0] outputB,
  output logic             outputBusy,
  output logic             outputWrap
);

  localparam int CW = ($clog2(DWELL + 1) > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(NSTATES - 1);
  localparam logic [CW-1:0]    DWELL_V = CW'(DWELL);

  logic [WIDTH-1:0] st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             i_prev_q, i_prev_d;
  logic             wrap_q, wrap_d;
  logic             rise;
  logic             move;

  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      st_q     <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      i_prev_q <= inputI;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      i_prev_q <= i_prev_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    wrap_d   = 1'b0;
    i_prev_d = inputI;
    move     = 1'b0;
    rise     = inputI & ~i_prev_q;
    // A saturated request never counts as accepted, so dwell only starts on a real move.
    if (rise && (cnt_q == '0)) begin
      if (!inputS) begin
        if (st_q < LAST) begin
          st_d = st_q + WIDTH'(1);
          move = 1'b1;
        end else if (WRAP != 0) begin
          st_d   = '0;
          wrap_d = 1'b1;
          move   = 1'b1;
        end
      end else begin
        if (st_q != '0) begin
          st_d = st_q - WIDTH'(1);
          move = 1'b1;
        end else if (WRAP != 0) begin
          st_d   = LAST;
          wrap_d = 1'b1;
          move   = 1'b1;
        end
      end
    end
    if (move) begin
      cnt_d = DWELL_V;
    end
  end

  assign outputB    = (GRAY != 0) ? (st_q ^ (st_q >> 1)) : st_q;
  assign outputBusy = (cnt_q != '0);
  assign outputWrap = wrap_q;

endmodule

// File: tb/tb_moore_seq_ctrl.sv
// tb/tb_moore_seq_ctrl.sv - scoreboard bench for moore_seq_ctrl across three parameter sets.
module tb_moore_seq_ctrl;

  logic clk = 1'b0;
  logic rst, in_i, in_s;
  logic [1:0] b0, b2;
  logic [2:0] b1;
  logic busy0, busy1, busy2, wrp0, wrp1, wrp2;

  always #5 clk = ~clk;

  moore_seq_ctrl #(.WIDTH(2), .NSTATES(4), .DWELL(3), .WRAP(1), .GRAY(0)) u_def (
    .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
    .outputB(b0), .outputBusy(busy0), .outputWrap(wrp0));
  moore_seq_ctrl #(.WIDTH(3), .NSTATES(5), .DWELL(2), .WRAP(0), .GRAY(1)) u_sat (
    .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
    .outputB(b1), .outputBusy(busy1), .outputWrap(wrp1));
  moore_seq_ctrl #(.WIDTH(2), .NSTATES(3), .DWELL(0), .WRAP(1), .GRAY(1)) u_n3 (
    .inputClk(clk), .inputReset(rst), .inputI(in_i), .inputS(in_s),
    .outputB(b2), .outputBusy(busy2), .outputWrap(wrp2));

  localparam int NS[3] = '{4, 5, 3};
  localparam int DW[3] = '{3, 2, 0};
  localparam int WR[3] = '{1, 0, 1};
  localparam int GR[3] = '{0, 1, 1};

  typedef struct packed {
    logic [2:0] b0, b1, b2;
    logic [2:0] busy, wrp;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int pos[3], last[3], cyc;
  bit iprev[3], wf[3];

  // Reference: positions as integers, dwell as "edge of last accepted move".
  task automatic drive(input bit r, input bit i, input bit s);
    exp_t e;
    int np;
    @(negedge clk);
    rst = r; in_i = i; in_s = s;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        pos[k] = 0; last[k] = -1000; wf[k] = 0; iprev[k] = i;
      end else begin
        wf[k] = 0;
        if (i && !iprev[k] && (cyc - 1 >= last[k] + DW[k])) begin
          np = s ? pos[k] - 1 : pos[k] + 1;
          if (np >= 0 && np < NS[k]) begin
            pos[k] = np; last[k] = cyc;
          end else if (WR[k] != 0) begin
            pos[k] = s ? NS[k] - 1 : 0; last[k] = cyc; wf[k] = 1;
          end
        end
        iprev[k] = i;
      end
    end
    e.b0 = 3'(GR[0] != 0 ? (pos[0] ^ (pos[0] >> 1)) : pos[0]);
    e.b1 = 3'(GR[1] != 0 ? (pos[1] ^ (pos[1] >> 1)) : pos[1]);
    e.b2 = 3'(GR[2] != 0 ? (pos[2] ^ (pos[2] >> 1)) : pos[2]);
    for (int k = 0; k < 3; k++) begin
      e.busy[k] = (cyc < last[k] + DW[k]);
      e.wrp[k]  = wf[k];
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s cycle-entry got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("def.outputB", int'(b0), int'(e.b0));
        chk("def.outputBusy", int'(busy0), int'(e.busy[0]));
        chk("def.outputWrap", int'(wrp0), int'(e.wrp[0]));
        chk("sat.outputB", int'(b1), int'(e.b1));
        chk("sat.outputBusy", int'(busy1), int'(e.busy[1]));
        chk("sat.outputWrap", int'(wrp1), int'(e.wrp[1]));
        chk("n3.outputB", int'(b2), int'(e.b2));
        chk("n3.outputBusy", int'(busy2), int'(e.busy[2]));
        chk("n3.outputWrap", int'(wrp2), int'(e.wrp[2]));
      end
    end
  end

  initial begin : stim
    rst = 1'b1; in_i = 1'b0; in_s = 1'b0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      pos[k] = 0; last[k] = -1000; iprev[k] = 0; wf[k] = 0;
    end
    drive(1, 0, 0); drive(1, 0, 0);
    // Four spaced up-pulses: wrap on the fourth for the default instance.
    for (int p = 0; p < 4; p++) begin
      drive(0, 1, 0);
      for (int g = 0; g < 5; g++) drive(0, 0, 0);
    end
    // Second rise 2 cycles after first is dropped; third at +4 is accepted.
    drive(0, 1, 0); drive(0, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 0, 0);
    for (int g = 0; g < 5; g++) drive(0, 0, 0);
    // Down-steps from 0 after reset: wrap or saturate depending on instance.
    drive(1, 0, 0);
    for (int p = 0; p < 6; p++) begin
      drive(0, 1, 1); drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
    end
    // Up-steps past the top to exercise saturation.
    for (int p = 0; p < 7; p++) begin
      drive(0, 1, 0); drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    end
    // Reset mid-dwell with inputI held high through and after reset.
    drive(0, 1, 0); drive(0, 0, 0); drive(0, 1, 0);
    drive(1, 1, 0); drive(1, 1, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(0, 1, 0);
    drive(0, 0, 0); drive(0, 1, 0); drive(0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1) != 0);
    end
    drive(0, 0, 0);
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard-drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
